// File: rtl/hwpf_issue_queue.sv
// hwpf_issue_queue: issue stage of the next-line prefetcher.
// Buffers line-aligned prefetch addresses in a small FIFO, drops duplicates of
// lines still queued or recently issued (round-robin filter), throttles issue
// with a post-handshake idle gap and yields to CPU demand traffic.
// Optional statistics counters are enabled with the macro HWPF_ISSUE_STATS_EN.
module hwpf_issue_queue #(
    parameter int ADDR_WIDTH     = 40,
    parameter int LINE_BYTES     = 64,
    parameter int FIFO_DEPTH     = 4,
    parameter int FILTER_ENTRIES = 8,
    parameter int MIN_GAP        = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  lock_i,
    input  logic                  cpu_busy_i,
    input  logic                  pf_req_valid_i,
    output logic                  pf_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] pf_req_addr_i,
    output logic                  dcache_req_valid_o,
    input  logic                  dcache_req_ready_i,
    output logic [ADDR_WIDTH-1:0] dcache_req_addr_o
`ifdef HWPF_ISSUE_STATS_EN
    ,
    output logic [31:0]           stat_issued_o,
    output logic [31:0]           stat_dropped_o,
    output logic [31:0]           stat_full_o
`endif
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FLT_W = (FILTER_ENTRIES > 1) ? $clog2(FILTER_ENTRIES) : 1;
    localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFF_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP
    } state_e;

    // Issue FSM and its registered outputs
    state_e                  state_q;
    logic                    valid_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [GAP_W-1:0]        gap_q;

    // Pending-request FIFO
    logic [ADDR_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;

    // Recently-issued line filter
    logic [ADDR_WIDTH-1:0]   flt_line_q [FILTER_ENTRIES];
    logic [FILTER_ENTRIES-1:0] flt_vld_q, flt_vld_d;
    logic [FLT_W-1:0]        repl_q, repl_d;

    logic [ADDR_WIDTH-1:0]   req_line;
    logic                    full;
    logic                    empty;
    logic                    accept;
    logic                    dup_hit;
    logic                    push;
    logic                    pop;

    assign req_line = pf_req_addr_i & LINE_MASK;
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);

    // Acceptance looks only at registered occupancy; a pop in the same cycle does not free a slot early.
    assign pf_req_ready_o = !rst_i && !full && !lock_i && !flush_i;
    assign accept         = pf_req_valid_i && pf_req_ready_o;
    assign push           = accept && !dup_hit;
    assign pop            = valid_q && dcache_req_ready_i;

    assign dcache_req_valid_o = valid_q;
    assign dcache_req_addr_o  = addr_q;

    // Duplicate detection against every occupied FIFO slot (head included) and every valid filter entry
    always_comb begin
        logic [PTR_W-1:0] off;
        dup_hit = 1'b0;
        off     = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, off} < count_q) && (fifo_mem_q[i] == req_line)) begin
                dup_hit = 1'b1;
            end
        end
        for (int j = 0; j < FILTER_ENTRIES; j++) begin
            if (flt_vld_q[j] && (flt_line_q[j] == req_line)) begin
                dup_hit = 1'b1;
            end
        end
    end

    // Next-state for FIFO pointers/occupancy and filter bookkeeping; flush overrides push and pop
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        flt_vld_d = flt_vld_q;
        repl_d    = repl_q;
        if (flush_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            flt_vld_d = '0;
            repl_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d          = rd_ptr_q + PTR_W'(1);
                flt_vld_d[repl_q] = 1'b1;
                repl_d            = (repl_q == FLT_W'(FILTER_ENTRIES - 1)) ? '0 : repl_q + FLT_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            flt_vld_q <= '0;
            repl_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            flt_vld_q <= flt_vld_d;
            repl_q    <= repl_d;
        end
    end

    // Line storage; contents are only meaningful where the matching valid/occupancy state says so
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            fifo_mem_q[wr_ptr_q] <= req_line;
        end
        if (pop && !flush_i) begin
            flt_line_q[repl_q] <= addr_q;
        end
    end

    // Issue FSM: a presented request is never withdrawn by lock/busy, only by flush
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            gap_q   <= '0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            gap_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!empty && !lock_i && !cpu_busy_i) begin
                        state_q <= S_ISSUE;
                        valid_q <= 1'b1;
                        addr_q  <= fifo_mem_q[rd_ptr_q];
                    end
                end
                S_ISSUE: begin
                    if (dcache_req_ready_i) begin
                        valid_q <= 1'b0;
                        if (MIN_GAP == 0) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_GAP;
                            gap_q   <= GAP_W'(MIN_GAP);
                        end
                    end
                end
                S_GAP: begin
                    gap_q <= gap_q - GAP_W'(1);
                    if (gap_q <= GAP_W'(1)) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef HWPF_ISSUE_STATS_EN
    logic [31:0] stat_issued_q;
    logic [31:0] stat_dropped_q;
    logic [31:0] stat_full_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    // Saturating event counters; survive flush, cleared only by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_issued_q  <= '0;
            stat_dropped_q <= '0;
            stat_full_q    <= '0;
        end else begin
            if (pop) begin
                stat_issued_q <= sat_inc(stat_issued_q);
            end
            if (accept && dup_hit) begin
                stat_dropped_q <= sat_inc(stat_dropped_q);
            end
            if (pf_req_valid_i && full) begin
                stat_full_q <= sat_inc(stat_full_q);
            end
        end
    end

    assign stat_issued_o  = stat_issued_q;
    assign stat_dropped_o = stat_dropped_q;
    assign stat_full_o    = stat_full_q;
`endif

endmodule

// File: tb/tb_hwpf_issue_queue.sv
// Directed self-checking bench for hwpf_issue_queue (default parameters).
module tb_hwpf_issue_queue;

    localparam int AW = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          lock;
    logic          busy;
    logic          pvld;
    logic          pready;
    logic [AW-1:0] paddr;
    logic          dvalid;
    logic          dready;
    logic [AW-1:0] daddr;
`ifdef HWPF_ISSUE_STATS_EN
    logic [31:0]   st_issued;
    logic [31:0]   st_dropped;
    logic [31:0]   st_full;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hwpf_issue_queue dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .flush_i            (flush),
        .lock_i             (lock),
        .cpu_busy_i         (busy),
        .pf_req_valid_i     (pvld),
        .pf_req_ready_o     (pready),
        .pf_req_addr_i      (paddr),
        .dcache_req_valid_o (dvalid),
        .dcache_req_ready_i (dready),
        .dcache_req_addr_o  (daddr)
`ifdef HWPF_ISSUE_STATS_EN
        ,
        .stat_issued_o      (st_issued),
        .stat_dropped_o     (st_dropped),
        .stat_full_o        (st_full)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) until dcache_req_valid_o is seen high.
    task automatic wait_valid(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (dvalid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Offer one request until accepted, then expect it to be issued (or not) with dready=1.
    task automatic push_wait(input logic [AW-1:0] a, input bit exp_issue, input string tag);
        bit ok;
        bit seen;
        ok    = 1'b0;
        pvld  = 1'b1;
        paddr = a;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (pready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_accepted"}, 64'(ok), 64'd1);
        tick();
        pvld = 1'b0;
        if (exp_issue) begin
            wait_valid(20, seen);
            chk({tag, "_issued"}, 64'(seen), 64'd1);
            chk({tag, "_addr"}, 64'(daddr), 64'(a));
            tick();
        end else begin
            seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (dvalid) seen = 1'b1;
                tick();
            end
            chk({tag, "_not_issued"}, 64'(seen), 64'd0);
        end
    endtask

    initial begin
        logic [AW-1:0] lines [5];
        logic [AW-1:0] fl    [9];
        int            got;
        int            nvalid;

        rst    = 1'b1;
        flush  = 1'b0;
        lock   = 1'b0;
        busy   = 1'b0;
        pvld   = 1'b0;
        paddr  = '0;
        dready = 1'b0;

        // ---- reset state
        tick();
        tick();
        chk("rst_ready", 64'(pready), 64'd0);
        chk("rst_valid", 64'(dvalid), 64'd0);
        chk("rst_addr", 64'(daddr), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(pready), 64'd1);
        tick();

        // ---- single request: valid in N+2, then 2 idle gap cycles
        pvld   = 1'b1;
        paddr  = 40'h00_1000_0047;
        dready = 1'b1;
        #1;
        chk("t1_ready", 64'(pready), 64'd1);
        tick();
        pvld = 1'b0;
        chk("t1_n1_valid", 64'(dvalid), 64'd0);
        tick();
        chk("t1_n2_valid", 64'(dvalid), 64'd1);
        chk("t1_n2_addr", 64'(daddr), 64'h00_1000_0040);
        tick();
        chk("t1_gap1_valid", 64'(dvalid), 64'd0);
        tick();
        chk("t1_gap2_valid", 64'(dvalid), 64'd0);
        repeat (3) tick();

        // ---- duplicate drop: 0x2000, 0x2010 (same line), 0x2000 -> one issue
        pvld  = 1'b1;
        paddr = 40'h2000;
        #1;
        chk("t2_acc0", 64'(pready), 64'd1);
        tick();
        paddr = 40'h2010;
        #1;
        chk("t2_acc1", 64'(pready), 64'd1);
        chk("t2_m1_valid", 64'(dvalid), 64'd0);
        tick();
        paddr = 40'h2000;
        #1;
        chk("t2_acc2", 64'(pready), 64'd1);
        chk("t2_m2_valid", 64'(dvalid), 64'd1);
        chk("t2_m2_addr", 64'(daddr), 64'h2000);
        tick();
        pvld   = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            if (dvalid) nvalid++;
            tick();
        end
        chk("t2_no_second_issue", 64'(nvalid), 64'd0);
        push_wait(40'h2000, 1'b0, "t2_filter_drop");
        repeat (3) tick();

        // ---- full / backpressure and FIFO order
        lines[0] = 40'h3000;
        lines[1] = 40'h3040;
        lines[2] = 40'h3080;
        lines[3] = 40'h30C0;
        lines[4] = 40'h3100;
        dready   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pvld  = 1'b1;
            paddr = lines[k];
            #1;
            chk($sformatf("t3_acc%0d", k), 64'(pready), 64'd1);
            tick();
        end
        paddr = lines[4];
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t3_full_ready%0d", k), 64'(pready), 64'd0);
            chk($sformatf("t3_hold_valid%0d", k), 64'(dvalid), 64'd1);
            chk($sformatf("t3_hold_addr%0d", k), 64'(daddr), 64'(lines[0]));
            tick();
        end
        dready = 1'b1;
        #1;
        chk("t3_no_bypass_ready", 64'(pready), 64'd0);
        chk("t3_hs_addr", 64'(daddr), 64'(lines[0]));
        tick();
        #1;
        chk("t3_after_pop_ready", 64'(pready), 64'd1);
        chk("t3_after_pop_valid", 64'(dvalid), 64'd0);
        tick();
        pvld = 1'b0;
        got  = 0;
        for (int i = 0; i < 40; i++) begin
            if (got < 4 && dvalid) begin
                chk($sformatf("t3_order%0d", got), 64'(daddr), 64'(lines[got + 1]));
                got++;
            end
            tick();
        end
        chk("t3_issue_count", 64'(got), 64'd4);

        // ---- cpu_busy stall in IDLE, lock during ISSUE
        dready = 1'b0;
        busy   = 1'b1;
        pvld   = 1'b1;
        paddr  = 40'h4000;
        #1;
        chk("t4_acc", 64'(pready), 64'd1);
        tick();
        pvld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_busy_valid%0d", i), 64'(dvalid), 64'd0);
            tick();
        end
        busy = 1'b0;
        tick();
        chk("t4_issue_valid", 64'(dvalid), 64'd1);
        chk("t4_issue_addr", 64'(daddr), 64'h4000);
        lock = 1'b1;
        busy = 1'b1;
        #1;
        chk("t4_lock_ready", 64'(pready), 64'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("t4_lock_valid%0d", i), 64'(dvalid), 64'd1);
            chk($sformatf("t4_lock_addr%0d", i), 64'(daddr), 64'h4000);
        end
        dready = 1'b1;
        tick();
        chk("t4_hs_done", 64'(dvalid), 64'd0);
        lock = 1'b0;
        busy = 1'b0;
        repeat (4) tick();

        // ---- flush mid-issue
        dready = 1'b0;
        pvld   = 1'b1;
        paddr  = 40'h5000;
        #1;
        chk("t5_acc", 64'(pready), 64'd1);
        tick();
        pvld = 1'b0;
        tick();
        chk("t5_valid", 64'(dvalid), 64'd1);
        chk("t5_addr", 64'(daddr), 64'h5000);
        flush = 1'b1;
        #1;
        chk("t5_flush_ready", 64'(pready), 64'd0);
        tick();
        flush = 1'b0;
        chk("t5_flushed_valid", 64'(dvalid), 64'd0);
        nvalid = 0;
        for (int i = 0; i < 6; i++) begin
            if (dvalid) nvalid++;
            tick();
        end
        chk("t5_fifo_empty", 64'(nvalid), 64'd0);
        dready = 1'b1;
        push_wait(40'h5000, 1'b1, "t5_repush");
        push_wait(40'h4000, 1'b1, "t5_filter_cleared");
        repeat (3) tick();

        // ---- filter wrap: 9 distinct lines evict the first
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        for (int k = 0; k < 9; k++) begin
            fl[k] = 40'h6000 + 40'(k * 64);
        end
        for (int k = 0; k < 9; k++) begin
            push_wait(fl[k], 1'b1, $sformatf("t6_line%0d", k));
        end
        push_wait(fl[0], 1'b1, "t6_evicted_A");
        push_wait(fl[8], 1'b0, "t6_kept_I");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
